// File: rtl/taus_seed_gen.sv
// Dual taus88 uniform source feeding the Box-Muller seed inputs a/b, with
// seed shadow registers, warm-up discard and a valid/ready output stage.
module taus_seed_gen #(
  parameter int          WARMUP     = 16,
  parameter int          CNT_W      = 8,
  parameter logic [31:0] DEF_SEED_A = 32'h1234_5678,
  parameter logic [31:0] DEF_SEED_B = 32'h8765_4321
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        seed_we,
  input  logic [2:0]  seed_sel,
  input  logic [31:0] seed_data,
  input  logic        seed_commit,
  input  logic        ordy,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        ovalid,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = (WARMUP == 0) ? '0 : CNT_W'(WARMUP - 1);
  localparam state_t START_ST = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  function automatic logic [31:0] step1(input logic [31:0] s);
    logic [31:0] t;
    t = ((s << 13) ^ s) >> 19;
    return ((s & 32'hFFFF_FFFE) << 12) ^ t;
  endfunction

  function automatic logic [31:0] step2(input logic [31:0] s);
    logic [31:0] t;
    t = ((s << 2) ^ s) >> 25;
    return ((s & 32'hFFFF_FFF8) << 4) ^ t;
  endfunction

  function automatic logic [31:0] step3(input logic [31:0] s);
    logic [31:0] t;
    t = ((s << 3) ^ s) >> 11;
    return ((s & 32'hFFFF_FFF0) << 17) ^ t;
  endfunction

  // Degenerate seeds would lock a component at zero, so force a minimum bit.
  function automatic logic [31:0] fix1(input logic [31:0] s);
    return (s < 32'd2) ? (s | 32'd2) : s;
  endfunction

  function automatic logic [31:0] fix2(input logic [31:0] s);
    return (s < 32'd8) ? (s | 32'd8) : s;
  endfunction

  function automatic logic [31:0] fix3(input logic [31:0] s);
    return (s < 32'd16) ? (s | 32'd16) : s;
  endfunction

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             warm, warm_nxt;
  logic             advance, load_out, ovalid_nxt;

  logic [31:0] shadow   [6];
  logic [31:0] seed_eff [6];
  logic [31:0] ca1, ca2, ca3, cb1, cb2, cb3;
  logic [31:0] na1, na2, na3, nb1, nb2, nb3;
  logic [31:0] out_a, out_b;

  // A word written in the commit cycle is seen by that commit.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      seed_eff[i] = (seed_we && seed_sel == 3'(i)) ? seed_data : shadow[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) begin
        shadow[i]     <= DEF_SEED_A;
        shadow[i + 3] <= DEF_SEED_B;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (seed_we && seed_sel == 3'(i)) shadow[i] <= seed_data;
      end
    end
  end

  assign na1   = step1(ca1);
  assign na2   = step2(ca2);
  assign na3   = step3(ca3);
  assign nb1   = step1(cb1);
  assign nb2   = step2(cb2);
  assign nb3   = step3(cb3);
  assign out_a = na1 ^ na2 ^ na3;
  assign out_b = nb1 ^ nb2 ^ nb3;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ca1 <= fix1(DEF_SEED_A);
      ca2 <= fix2(DEF_SEED_A);
      ca3 <= fix3(DEF_SEED_A);
      cb1 <= fix1(DEF_SEED_B);
      cb2 <= fix2(DEF_SEED_B);
      cb3 <= fix3(DEF_SEED_B);
    end else if (seed_commit) begin
      ca1 <= fix1(seed_eff[0]);
      ca2 <= fix2(seed_eff[1]);
      ca3 <= fix3(seed_eff[2]);
      cb1 <= fix1(seed_eff[3]);
      cb2 <= fix2(seed_eff[4]);
      cb3 <= fix3(seed_eff[5]);
    end else if (advance) begin
      ca1 <= na1;
      ca2 <= na2;
      ca3 <= na3;
      cb1 <= nb1;
      cb2 <= nb2;
      cb3 <= nb3;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      warm   <= 1'b0;
      ovalid <= 1'b0;
      a      <= '0;
      b      <= '0;
    end else begin
      state  <= next_state;
      cnt    <= cnt_nxt;
      warm   <= warm_nxt;
      ovalid <= ovalid_nxt;
      if (load_out) begin
        a <= out_a;
        b <= out_b;
      end
    end
  end

  always_comb begin
    next_state = state;
    cnt_nxt    = cnt;
    warm_nxt   = warm;
    advance    = 1'b0;
    load_out   = 1'b0;
    ovalid_nxt = ovalid;
    unique case (state)
      ST_IDLE: begin
        ovalid_nxt = 1'b0;
        if (en) begin
          if (warm) begin
            next_state = ST_RUN;
          end else begin
            next_state = START_ST;
            cnt_nxt    = '0;
          end
        end
      end
      ST_WARMUP: begin
        if (!en) begin
          next_state = ST_IDLE;
        end else begin
          advance = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            next_state = ST_RUN;
            warm_nxt   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!en) begin
          next_state = ST_IDLE;
          ovalid_nxt = 1'b0;
        end else if (!ovalid || ordy) begin
          advance    = 1'b1;
          load_out   = 1'b1;
          ovalid_nxt = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    // A commit overrides everything and restarts the warm-up from the new seeds.
    if (seed_commit) begin
      next_state = en ? START_ST : ST_IDLE;
      cnt_nxt    = '0;
      warm_nxt   = 1'b0;
      advance    = 1'b0;
      load_out   = 1'b0;
      ovalid_nxt = 1'b0;
    end
  end

  assign busy = (state == ST_WARMUP);

endmodule

// File: tb/tb_taus_seed_gen.sv
// Directed bench for taus_seed_gen: three instances (WARMUP 0, 1, 16) share
// one stimulus stream; each scenario checks the instance it targets.
module tb_taus_seed_gen;

  localparam logic [31:0] DEF_A = 32'h1234_5678;
  localparam logic [31:0] DEF_B = 32'h8765_4321;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic        seed_we;
  logic [2:0]  seed_sel;
  logic [31:0] seed_data;
  logic        seed_commit;
  logic        ordy;

  logic [31:0] a0, b0, a1, b1, a16, b16;
  logic        v0, v1, v16, busy0, busy1, busy16;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_a [3];
  logic [31:0] m_b [3];
  logic [31:0] exp_a, exp_b;

  always #5 clk = ~clk;

  taus_seed_gen #(.WARMUP(0)) dut0 (
    .clk(clk), .resetn(resetn), .en(en), .seed_we(seed_we), .seed_sel(seed_sel),
    .seed_data(seed_data), .seed_commit(seed_commit), .ordy(ordy),
    .a(a0), .b(b0), .ovalid(v0), .busy(busy0)
  );

  taus_seed_gen #(.WARMUP(1)) dut1 (
    .clk(clk), .resetn(resetn), .en(en), .seed_we(seed_we), .seed_sel(seed_sel),
    .seed_data(seed_data), .seed_commit(seed_commit), .ordy(ordy),
    .a(a1), .b(b1), .ovalid(v1), .busy(busy1)
  );

  taus_seed_gen dut16 (
    .clk(clk), .resetn(resetn), .en(en), .seed_we(seed_we), .seed_sel(seed_sel),
    .seed_data(seed_data), .seed_commit(seed_commit), .ordy(ordy),
    .a(a16), .b(b16), .ovalid(v16), .busy(busy16)
  );

  function automatic logic [31:0] n1(input logic [31:0] s);
    logic [31:0] t;
    t = ((s << 13) ^ s) >> 19;
    return ((s & 32'hFFFF_FFFE) << 12) ^ t;
  endfunction

  function automatic logic [31:0] n2(input logic [31:0] s);
    logic [31:0] t;
    t = ((s << 2) ^ s) >> 25;
    return ((s & 32'hFFFF_FFF8) << 4) ^ t;
  endfunction

  function automatic logic [31:0] n3(input logic [31:0] s);
    logic [31:0] t;
    t = ((s << 3) ^ s) >> 11;
    return ((s & 32'hFFFF_FFF0) << 17) ^ t;
  endfunction

  task automatic model_init(input logic [31:0] a_s1, a_s2, a_s3, b_s1, b_s2, b_s3);
    m_a[0] = a_s1; m_a[1] = a_s2; m_a[2] = a_s3;
    m_b[0] = b_s1; m_b[1] = b_s2; m_b[2] = b_s3;
    // Small seeds get the lowest legal bit set.
    if (m_a[0][31:1] == 0) m_a[0][1] = 1'b1;
    if (m_a[1][31:3] == 0) m_a[1][3] = 1'b1;
    if (m_a[2][31:4] == 0) m_a[2][4] = 1'b1;
    if (m_b[0][31:1] == 0) m_b[0][1] = 1'b1;
    if (m_b[1][31:3] == 0) m_b[1][3] = 1'b1;
    if (m_b[2][31:4] == 0) m_b[2][4] = 1'b1;
  endtask

  task automatic model_adv();
    m_a[0] = n1(m_a[0]); m_a[1] = n2(m_a[1]); m_a[2] = n3(m_a[2]);
    m_b[0] = n1(m_b[0]); m_b[1] = n2(m_b[1]); m_b[2] = n3(m_b[2]);
    exp_a = m_a[0] ^ m_a[1] ^ m_a[2];
    exp_b = m_b[0] ^ m_b[1] ^ m_b[2];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_seed(input logic [2:0] sel, input logic [31:0] d);
    seed_we = 1'b1; seed_sel = sel; seed_data = d;
    tick();
    seed_we = 1'b0;
  endtask

  task automatic commit_idle();
    en = 1'b0; seed_commit = 1'b1;
    tick();
    seed_commit = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (a0 !== 32'h0) begin errors++; $display("FAIL reset_a got %h want 0", a0); end
    checks++; if (b0 !== 32'h0) begin errors++; $display("FAIL reset_b got %h want 0", b0); end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_ovalid got %b want 0", v0); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy16); end
    #2 resetn = 1'b1;
    tick(); tick();
    checks++; if (v0 !== 1'b0 || busy16 !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset ovalid=%b busy=%b want 0/0", v0, busy16);
    end
  endtask

  task automatic test_default_run();
    model_init(DEF_A, DEF_A, DEF_A, DEF_B, DEF_B, DEF_B);
    en = 1'b1;
    tick();
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL def_first_edge ovalid=%b want 0", v0); end
    for (int i = 0; i < 4; i++) begin
      tick();
      model_adv();
      checks++; if (v0 !== 1'b1 || a0 !== exp_a || b0 !== exp_b) begin
        errors++;
        $display("FAIL def_word%0d got v=%b a=%h b=%h want 1 %h %h", i, v0, a0, b0, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    tick();
    #2 resetn = 1'b0;
    #1;
    checks++; if (a0 !== 32'h0 || b0 !== 32'h0 || v0 !== 1'b0) begin
      errors++; $display("FAIL async_reset got a=%h b=%h v=%b want 0 0 0", a0, b0, v0);
    end
    en = 1'b0;
    tick();
    #2 resetn = 1'b1;
    tick();
    checks++; if (v0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle ovalid=%b busy=%b want 0/0", v0, busy0);
    end
    model_init(DEF_A, DEF_A, DEF_A, DEF_B, DEF_B, DEF_B);
    en = 1'b1;
    tick(); tick();
    model_adv();
    checks++; if (v0 !== 1'b1 || a0 !== exp_a || b0 !== exp_b) begin
      errors++; $display("FAIL reload_defaults got v=%b a=%h b=%h want 1 %h %h", v0, a0, b0, exp_a, exp_b);
    end
  endtask

  task automatic test_zero_seed_warmup0();
    en = 1'b0;
    for (int i = 0; i < 6; i++) write_seed(3'(i), 32'h0);
    commit_idle();
    model_init(0, 0, 0, 0, 0, 0);
    en = 1'b1;
    tick();
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL zero_edge1 ovalid=%b want 0", v0); end
    tick();
    model_adv();
    checks++; if (v0 !== 1'b1 || a0 !== 32'h0020_2080 || b0 !== 32'h0020_2080) begin
      errors++; $display("FAIL zero_pair1 got v=%b a=%h b=%h want 1 00202080 00202080", v0, a0, b0);
    end
    tick();
    model_adv();
    checks++; if (a0 !== 32'h0200_2C80 || b0 !== 32'h0200_2C80) begin
      errors++; $display("FAIL zero_pair2 got a=%h b=%h want 02002c80 02002c80", a0, b0);
    end
  endtask

  task automatic test_warmup1();
    commit_idle();
    checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin
      errors++; $display("FAIL commit_drop got v0=%b v1=%b want 0/0", v0, v1);
    end
    model_init(0, 0, 0, 0, 0, 0);
    en = 1'b1;
    tick();
    checks++; if (busy1 !== 1'b1 || v1 !== 1'b0) begin
      errors++; $display("FAIL w1_edge1 busy=%b v=%b want 1/0", busy1, v1);
    end
    tick();
    model_adv();
    checks++; if (busy1 !== 1'b0 || v1 !== 1'b0) begin
      errors++; $display("FAIL w1_edge2 busy=%b v=%b want 0/0", busy1, v1);
    end
    tick();
    model_adv();
    checks++; if (v1 !== 1'b1 || a1 !== 32'h0200_2C80 || b1 !== 32'h0200_2C80) begin
      errors++; $display("FAIL w1_edge3 got v=%b a=%h b=%h want 1 02002c80 02002c80", v1, a1, b1);
    end
  endtask

  task automatic test_backpressure();
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (v0 !== 1'b1 || a0 !== exp_a || b0 !== exp_b) begin
        errors++; $display("FAIL hold%0d got v=%b a=%h b=%h want 1 %h %h", i, v0, a0, b0, exp_a, exp_b);
      end
    end
    ordy = 1'b1;
    tick();
    model_adv();
    checks++; if (a0 !== exp_a || b0 !== exp_b) begin
      errors++; $display("FAIL after_hold got a=%h b=%h want %h %h", a0, b0, exp_a, exp_b);
    end
  endtask

  task automatic test_commit_write_through();
    write_seed(3'd0, 32'hDEAD_BEEF);
    model_adv();
    checks++; if (a0 !== exp_a || b0 !== exp_b) begin
      errors++; $display("FAIL we_no_disturb got a=%h b=%h want %h %h", a0, b0, exp_a, exp_b);
    end
    seed_we = 1'b1; seed_sel = 3'd0; seed_data = 32'h0; seed_commit = 1'b1;
    tick();
    seed_we = 1'b0; seed_commit = 1'b0;
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL commit_run_drop ovalid=%b want 0", v0); end
    tick();
    checks++; if (v0 !== 1'b1 || a0 !== 32'h0020_2080 || b0 !== 32'h0020_2080) begin
      errors++; $display("FAIL write_through got v=%b a=%h b=%h want 1 00202080 00202080", v0, a0, b0);
    end
  endtask

  task automatic test_en_gap();
    int n;
    logic [31:0] last_a;
    commit_idle();
    model_init(0, 0, 0, 0, 0, 0);
    en = 1'b1;
    n = 0;
    while (v16 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n != 18) begin errors++; $display("FAIL w16_latency got %0d edges want 18", n); end
    for (int i = 0; i < 17; i++) model_adv();
    checks++; if (a16 !== exp_a || b16 !== exp_b) begin
      errors++; $display("FAIL w16_first got a=%h b=%h want %h %h", a16, b16, exp_a, exp_b);
    end
    tick();
    model_adv();
    last_a = a16;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (v16 !== 1'b0) begin errors++; $display("FAIL gap%0d ovalid=%b want 0", i, v16); end
    end
    en = 1'b1;
    tick();
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL resume_busy got %b want 0", busy16); end
    tick();
    model_adv();
    checks++; if (v16 !== 1'b1 || a16 !== exp_a || b16 !== exp_b || a16 === last_a) begin
      errors++; $display("FAIL resume_word got v=%b a=%h b=%h want 1 %h %h", v16, a16, b16, exp_a, exp_b);
    end
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; seed_we = 1'b0; seed_sel = 3'd0;
    seed_data = 32'h0; seed_commit = 1'b0; ordy = 1'b1;
    test_reset();
    test_default_run();
    test_reset_mid_run();
    test_zero_seed_warmup0();
    test_warmup1();
    test_backpressure();
    test_commit_write_through();
    test_en_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
